// File: rtl/ripple_pkg.sv
// rtl/ripple_pkg.sv - shared types, direction constants and step function for the ripple count checker
//   state_t       : checker FSM states
//   DIR_DOWN/UP   : direction selector values
//   next_expected : value one step after ref_val in direction dir (caller truncates to its width)
package ripple_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALIGN = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam int DIR_DOWN = 0;
    localparam int DIR_UP   = 1;

    // Computed at 32 bits; truncating the result to WIDTH gives the mod 2^WIDTH step.
    function automatic logic [31:0] next_expected(input logic [31:0] ref_val, input int dir);
        return (dir == DIR_UP) ? ref_val + 32'd1 : ref_val - 32'd1;
    endfunction

endpackage

// File: rtl/count_settle_filter.sv
// rtl/count_settle_filter.sv - synchronizer plus stability filter for a glitchy asynchronous count bus
//   clk, rstn   : system clock, asynchronous active-low reset
//   raw         : asynchronous counter value
//   rearm       : forget the last accepted value so the settled value is accepted again
//   acc_value   : settled value (meaningful while acc_strobe is high)
//   acc_strobe  : one-cycle pulse when a new settled value is accepted
module count_settle_filter #(
    parameter int WIDTH      = 4,
    parameter int STABLE_CYC = 2
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] raw,
    input  logic             rearm,
    output logic [WIDTH-1:0] acc_value,
    output logic             acc_strobe
);

    localparam int CW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC);
    // The sample that loads the candidate counts as its first match and the
    // sample currently on s2 as the next one, so the strobe is raised once the
    // counter reaches STABLE_CYC-2 (giving a 2+STABLE_CYC cycle latency).
    localparam logic [CW-1:0] HIT = CW'((STABLE_CYC >= 2) ? STABLE_CYC - 2 : 0);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] last;
    logic             last_valid;
    logic [CW-1:0]    stab;
    logic             match;
    logic             is_new;

    assign match      = (s2 == cand);
    assign is_new     = !last_valid || (cand != last);
    assign acc_strobe = match && (stab == HIT) && is_new;
    assign acc_value  = cand;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1         <= '0;
            s2         <= '0;
            cand       <= '0;
            stab       <= '0;
            last       <= '0;
            last_valid <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (!match) begin
                cand <= s2;
                stab <= '0;
            end else if (stab != HIT) begin
                // Saturating at HIT lets a rearm re-accept an already settled value.
                stab <= stab + 1'b1;
            end
            if (rearm) begin
                last_valid <= 1'b0;
            end else if (acc_strobe) begin
                last       <= cand;
                last_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/ripple_count_checker.sv
// rtl/ripple_count_checker.sv - checks that a ripple counter bus steps by one in the configured direction
//   clk, rstn   : system clock, asynchronous active-low reset
//   cnt_in      : raw ripple counter output (asynchronous)
//   enable      : checker enable, low forces IDLE
//   clr_stats   : synchronous clear of err_count and wrap_count (wins over increments)
//   locked      : tracking a correct sequence
//   err_pulse   : one-cycle pulse per bad step while locked
//   err_count   : saturating bad-step count
//   wrap_count  : saturating good wrap-step count
module ripple_count_checker
    import ripple_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int DIR        = 0,
    parameter int STABLE_CYC = 2,
    parameter int LOCK_N     = 2,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [WIDTH-1:0] cnt_in,
    input  logic             enable,
    input  logic             clr_stats,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count
);

    localparam int GW = (LOCK_N < 2) ? 1 : $clog2(LOCK_N);
    localparam logic [GW-1:0]    LOCK_M1   = GW'(LOCK_N - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [WIDTH-1:0] WRAP_FROM = (DIR == DIR_UP) ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

    state_t           state;
    logic [WIDTH-1:0] ref_val;
    logic             has_ref;
    logic [GW-1:0]    good_cnt;
    logic [WIDTH-1:0] acc_value;
    logic             acc_strobe;
    logic             rearm;
    logic [WIDTH-1:0] exp_val;
    logic             step_good;
    logic             err_ev;
    logic             wrap_ev;

    // Held in IDLE so the value already on the bus is re-accepted as the new reference.
    assign rearm = (state == IDLE);

    count_settle_filter #(
        .WIDTH      (WIDTH),
        .STABLE_CYC (STABLE_CYC)
    ) u_filter (
        .clk        (clk),
        .rstn       (rstn),
        .raw        (cnt_in),
        .rearm      (rearm),
        .acc_value  (acc_value),
        .acc_strobe (acc_strobe)
    );

    assign exp_val   = WIDTH'(next_expected(32'(ref_val), DIR));
    assign step_good = (acc_value == exp_val);
    assign err_ev    = enable && (state == TRACK) && acc_strobe && !step_good;
    assign wrap_ev   = enable && (state != IDLE) && acc_strobe && has_ref
                       && step_good && (ref_val == WRAP_FROM);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            ref_val   <= '0;
            has_ref   <= 1'b0;
            good_cnt  <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            err_pulse <= err_ev;
            if (!enable) begin
                state  <= IDLE;
                locked <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= ALIGN;
                        good_cnt <= '0;
                        has_ref  <= 1'b0;
                    end
                    ALIGN: begin
                        if (acc_strobe) begin
                            ref_val <= acc_value;
                            has_ref <= 1'b1;
                            if (has_ref) begin
                                if (step_good) begin
                                    if (good_cnt == LOCK_M1) begin
                                        state    <= TRACK;
                                        locked   <= 1'b1;
                                        good_cnt <= '0;
                                    end else begin
                                        good_cnt <= good_cnt + 1'b1;
                                    end
                                end else begin
                                    good_cnt <= '0;
                                end
                            end
                        end
                    end
                    TRACK: begin
                        if (acc_strobe) begin
                            ref_val <= acc_value;
                            if (!step_good) begin
                                state    <= ALIGN;
                                locked   <= 1'b0;
                                good_cnt <= '0;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            err_count  <= '0;
            wrap_count <= '0;
        end else if (clr_stats) begin
            err_count  <= '0;
            wrap_count <= '0;
        end else begin
            if (err_ev && (err_count != CNT_MAX)) begin
                err_count <= err_count + 1'b1;
            end
            if (wrap_ev && (wrap_count != CNT_MAX)) begin
                wrap_count <= wrap_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ripple_count_checker.sv
// tb/tb_ripple_count_checker.sv - self-checking bench for ripple_count_checker
module tb_ripple_count_checker;

    localparam int LOCKN = 2;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic       clr_stats = 1'b0;
    logic [3:0] cnt_in = 4'hF;

    logic       locked, err_pulse;
    logic [7:0] err_count, wrap_count;
    logic       locked2, err_pulse2;
    logic [1:0] err_count2, wrap_count2;

    ripple_count_checker #(
        .WIDTH(4), .DIR(0), .STABLE_CYC(2), .LOCK_N(LOCKN), .CNT_W(8)
    ) dut (
        .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .enable(enable), .clr_stats(clr_stats),
        .locked(locked), .err_pulse(err_pulse), .err_count(err_count), .wrap_count(wrap_count)
    );

    ripple_count_checker #(
        .WIDTH(4), .DIR(0), .STABLE_CYC(2), .LOCK_N(LOCKN), .CNT_W(2)
    ) dut2 (
        .clk(clk), .rstn(rstn), .cnt_in(cnt_in), .enable(enable), .clr_stats(clr_stats),
        .locked(locked2), .err_pulse(err_pulse2), .err_count(err_count2), .wrap_count(wrap_count2)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int pulses   = 0;

    always @(negedge clk) begin
        if (err_pulse === 1'b1) pulses++;
    end

    // Sequence-level model: which settled values are accepted and what each one means.
    bit         m_have, m_last_v, m_locked;
    logic [3:0] m_ref, m_last;
    int         m_good, m_err, m_wrap, m_events;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int x, input int m);
        return (x > m) ? m : x;
    endfunction

    task automatic model_reset_align();
        m_have = 0; m_last_v = 0; m_locked = 0; m_good = 0;
    endtask

    task automatic model_accept(input logic [3:0] v);
        int expd;
        if (m_last_v && v == m_last) return;
        m_last = v; m_last_v = 1;
        if (!m_have) begin
            m_have = 1; m_ref = v;
            return;
        end
        expd = (int'(m_ref) + 15) % 16;
        if (int'(v) == expd) begin
            if (m_ref == 4'h0) m_wrap++;
            m_ref = v;
            if (!m_locked) begin
                m_good++;
                if (m_good >= LOCKN) begin m_locked = 1; m_good = 0; end
            end
        end else begin
            if (m_locked) begin m_err++; m_events++; m_locked = 0; end
            m_ref = v; m_good = 0;
        end
    endtask

    task automatic hold(input logic [3:0] v, input int n);
        cnt_in = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".locked"},  32'(locked),      32'(m_locked));
        chk({tag, ".locked2"}, 32'(locked2),     32'(m_locked));
        chk({tag, ".err8"},    32'(err_count),   32'(sat(m_err, 255)));
        chk({tag, ".err2"},    32'(err_count2),  32'(sat(m_err, 3)));
        chk({tag, ".wrap8"},   32'(wrap_count),  32'(sat(m_wrap, 255)));
        chk({tag, ".wrap2"},   32'(wrap_count2), 32'(sat(m_wrap, 3)));
        chk({tag, ".pulses"},  32'(pulses),      32'(m_events));
    endtask

    task automatic step(input logic [3:0] v, input string tag);
        hold(v, 8);
        model_accept(v);
        check_all(tag);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, ".locked"},  32'(locked),      0);
        chk({tag, ".pulse"},   32'(err_pulse),   0);
        chk({tag, ".err"},     32'(err_count),   0);
        chk({tag, ".wrap"},    32'(wrap_count),  0);
        chk({tag, ".locked2"}, 32'(locked2),     0);
        chk({tag, ".pulse2"},  32'(err_pulse2),  0);
        chk({tag, ".err2"},    32'(err_count2),  0);
        chk({tag, ".wrap2"},   32'(wrap_count2), 0);
    endtask

    initial begin
        logic [3:0] v;
        logic [3:0] g;
        logic [3:0] r;

        m_have = 0; m_last_v = 0; m_locked = 0;
        m_ref = '0; m_last = '0;
        m_good = 0; m_err = 0; m_wrap = 0; m_events = 0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        model_accept(4'hF);
        check_all("align_first");
        step(4'hE, "step_e");

        // Lock latency: locked rises 4 cycles after 1101 is driven
        cnt_in = 4'hD;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("lock_early", 32'(locked), 0);
        @(posedge clk);
        @(negedge clk);
        chk("lock_at_4", 32'(locked), 1);
        repeat (4) @(posedge clk);
        #1;
        model_accept(4'hD);
        check_all("locked_d");

        // Down to the wrap 0000 -> 1111
        for (int i = 12; i >= 0; i--) step(4'(i), "down");
        step(4'hF, "wrap1");
        chk("wrap_is_1", 32'(wrap_count), 1);
        for (int i = 14; i >= 8; i--) step(4'(i), "down2");

        // One-cycle glitch to 0000 on the way from 1000 to 0111
        hold(4'h0, 1);
        step(4'h7, "glitch");

        // Walk round to 1010, then a bad jump to 1000
        for (int i = 6; i >= 0; i--) step(4'(i), "down3");
        step(4'hF, "wrap2");
        for (int i = 14; i >= 10; i--) step(4'(i), "down4");
        cnt_in = 4'h8;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("bad_pulse_hi", 32'(err_pulse), 1);
        @(posedge clk);
        @(negedge clk);
        chk("bad_pulse_lo", 32'(err_pulse), 0);
        repeat (3) @(posedge clk);
        #1;
        model_accept(4'h8);
        check_all("bad_step");
        step(4'h7, "relock1");
        step(4'h6, "relock2");

        // Four more errors: the 2-bit instance saturates at 3
        for (int k = 0; k < 4; k++) begin
            r = m_ref;
            step(r - 4'd3, "sat_bad");
            step(r - 4'd4, "sat_g1");
            step(r - 4'd5, "sat_g2");
        end
        chk("sat_err2", 32'(err_count2), 3);
        chk("sat_err8", 32'(err_count), 5);

        // Clear coincident with a wrap step
        for (int k = 0; k < 16 && m_ref != 4'h0; k++) step(m_ref - 4'd1, "to_zero");
        cnt_in = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        clr_stats = 1'b1;
        @(posedge clk);
        #1;
        clr_stats = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        model_accept(4'hF);
        m_err = 0;
        m_wrap = 0;
        check_all("clr_wrap");

        // Randomized walk with glitches and bad jumps
        for (int k = 0; k < 60; k++) begin
            v = ($urandom_range(3) != 0) ? m_last - 4'd1 : 4'($urandom_range(15));
            if ($urandom_range(3) == 0) begin
                g = 4'($urandom_range(15));
                hold(g, 1);
            end
            step(v, "rand");
        end

        // enable low forces IDLE; re-enable re-accepts the settled value
        enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("disable_locked", 32'(locked), 0);
        model_reset_align();
        repeat (4) @(posedge clk);
        #1;
        check_all("idle_hold");
        enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        model_accept(cnt_in);
        check_all("reenable");
        step(m_ref - 4'd1, "reen1");
        step(m_ref - 4'd1, "reen2");
        chk("reen_locked", 32'(locked), 1);

        // Asynchronous reset mid-TRACK
        rstn = 1'b0;
        #2;
        check_zero("async_rst");
        m_err = 0; m_wrap = 0;
        model_reset_align();
        enable = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        enable = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        model_accept(cnt_in);
        check_all("post_rst_align");
        step(m_ref - 4'd1, "post_rst1");
        chk("post_rst1_unlocked", 32'(locked), 0);
        step(m_ref - 4'd1, "post_rst2");
        chk("post_rst2_locked", 32'(locked), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
